// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared defaults, FSM state type and address helper for the stack controller
package cpu_pkg;

    localparam logic [15:0] STACK_BASE_DEFAULT = 16'h0100;
    localparam logic [7:0]  RESET_SP_DEFAULT   = 8'hFF;
    localparam logic [8:0]  STACK_DEPTH        = 9'd256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_WR = 2'd1,
        POP_RD  = 2'd2
    } stack_state_t;

    // The stack lives in one 256-byte page, so the pointer only fills the low byte.
    function automatic logic [15:0] stack_addr(input logic [15:0] base, input logic [7:0] ptr);
        return base | {8'h00, ptr};
    endfunction

endpackage

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - byte-wide hardware stack controller driving a single-port RAM page
// Optional macro STACK_GUARD_EN blocks overflow/underflow accesses and latches a sticky stack_err.
module stack_controller
    import cpu_pkg::*;
#(
    parameter logic [15:0] STACK_BASE = STACK_BASE_DEFAULT,
    parameter logic [7:0]  RESET_SP   = RESET_SP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  push_data,
    output logic        cmd_ready,
    output logic        done,
    output logic [7:0]  pop_data,
    output logic [7:0]  sp,
    output logic        empty,
    output logic        full,
    output logic        stack_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);

    stack_state_t state;
    logic [8:0]   count;
    logic         err_sticky;
    logic         block_push;
    logic         block_pop;

    assign cmd_ready = (state == IDLE);
    assign empty     = (count == 9'd0);
    assign full      = (count == STACK_DEPTH);

`ifdef STACK_GUARD_EN
    assign block_push = full;
    assign block_pop  = empty;
`else
    assign block_push = 1'b0;
    assign block_pop  = 1'b0;
`endif

    // Memory strobes are registered on entry to the access state so reset kills them at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sp         <= RESET_SP;
            count      <= 9'd0;
            pop_data   <= 8'h00;
            done       <= 1'b0;
            stack_err  <= 1'b0;
            err_sticky <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wdata  <= 8'h00;
            mem_addr   <= stack_addr(STACK_BASE, RESET_SP);
        end else begin
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= 8'h00;
            stack_err <= err_sticky;
            case (state)
                IDLE: begin
                    if (push && pop) begin
                        stack_err <= 1'b1;
                    end else if (push) begin
                        if (block_push) begin
                            err_sticky <= 1'b1;
                            stack_err  <= 1'b1;
                        end else begin
                            state     <= PUSH_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= push_data;
                            mem_addr  <= stack_addr(STACK_BASE, sp);
                        end
                    end else if (pop) begin
                        if (block_pop) begin
                            err_sticky <= 1'b1;
                            stack_err  <= 1'b1;
                        end else begin
                            state    <= POP_RD;
                            mem_re   <= 1'b1;
                            mem_addr <= stack_addr(STACK_BASE, sp + 8'd1);
                        end
                    end
                end
                PUSH_WR: begin
                    sp       <= sp - 8'd1;
                    count    <= (count == STACK_DEPTH) ? count : count + 9'd1;
                    done     <= 1'b1;
                    mem_addr <= stack_addr(STACK_BASE, sp - 8'd1);
                    state    <= IDLE;
                end
                POP_RD: begin
                    pop_data <= mem_rdata;
                    sp       <= sp + 8'd1;
                    count    <= (count == 9'd0) ? count : count - 9'd1;
                    done     <= 1'b1;
                    mem_addr <= stack_addr(STACK_BASE, sp + 8'd1);
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - randomized and directed self-checking bench for stack_controller
module tb_stack_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic        cmd_ready, done, empty, full, stack_err, mem_we, mem_re;
    logic [7:0]  pop_data, sp, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic [7:0]  ram [256];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    stack_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .cmd_ready (cmd_ready),
        .done      (done),
        .pop_data  (pop_data),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .stack_err (stack_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = mem_re ? ram[mem_addr[7:0]] : 8'h00;

    // Reference model: a LIFO over a byte array, plus the one-cycle access slot of a command.
    logic [7:0] m_mem [256];
    logic [7:0] m_sp, m_pop, p_data, m_idx;
    int         m_cnt;
    int         p_kind;   // 0 none, 1 push access pending, 2 pop access pending
    bit         m_sticky, m_done, m_err;

    task automatic model_reset();
        m_sp = 8'hFF; m_cnt = 0; m_pop = 8'h00; m_sticky = 1'b0;
        m_done = 1'b0; m_err = 1'b0; p_kind = 0; p_data = 8'h00;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (p_kind == 1) begin
                m_mem[m_sp] = p_data;
                m_sp   = m_sp - 8'd1;
                m_cnt  = (m_cnt < 256) ? m_cnt + 1 : 256;
                m_done = 1'b1;
                p_kind = 0;
            end else if (p_kind == 2) begin
                m_idx  = m_sp + 8'd1;
                m_pop  = m_mem[m_idx];
                m_sp   = m_idx;
                m_cnt  = (m_cnt > 0) ? m_cnt - 1 : 0;
                m_done = 1'b1;
                p_kind = 0;
            end else if (push && pop) begin
                m_err = 1'b1;
            end else if (push) begin
                if (GUARD && m_cnt == 256) m_sticky = 1'b1;
                else begin p_kind = 1; p_data = push_data; end
            end else if (pop) begin
                if (GUARD && m_cnt == 0) m_sticky = 1'b1;
                else p_kind = 2;
            end
            m_err = m_err | m_sticky;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            m_idx = (p_kind == 2) ? m_sp + 8'd1 : m_sp;
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, p_kind == 0});
            check("mem_we", {31'd0, mem_we}, {31'd0, p_kind == 1});
            check("mem_re", {31'd0, mem_re}, {31'd0, p_kind == 2});
            check("mem_addr", {16'd0, mem_addr}, {16'd0, 8'h01, m_idx});
            check("mem_wdata", {24'd0, mem_wdata}, {24'd0, (p_kind == 1) ? p_data : 8'h00});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("stack_err", {31'd0, stack_err}, {31'd0, m_err});
            check("sp", {24'd0, sp}, {24'd0, m_sp});
            check("empty", {31'd0, empty}, {31'd0, m_cnt == 0});
            check("full", {31'd0, full}, {31'd0, m_cnt == 256});
            check("pop_data", {24'd0, pop_data}, {24'd0, m_pop});
        end
    end

    task automatic cyc(input logic p, input logic q, input logic [7:0] d);
        push = p; pop = q; push_data = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        push = 1'b0; pop = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    logic [7:0] old_byte;
    int r;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'h00;
            m_mem[i] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset_n = 1'b1;

        check("rst_sp", {24'd0, sp}, 32'hFF);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);

        cyc(1'b1, 1'b0, 8'hA5);
        check("a5_we", {31'd0, mem_we}, 32'd1);
        check("a5_addr", {16'd0, mem_addr}, 32'h01FF);
        cyc(1'b0, 1'b0, 8'h00);
        check("a5_done", {31'd0, done}, 32'd1);
        check("a5_sp", {24'd0, sp}, 32'hFE);
        check("a5_ram", {24'd0, ram[8'hFF]}, 32'hA5);

        do_reset();
        cyc(1'b1, 1'b0, 8'h11); cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h22); cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b0, 8'h00);
        check("pop1_done", {31'd0, done}, 32'd1);
        check("pop1_data", {24'd0, pop_data}, 32'h22);
        cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b0, 8'h00);
        check("pop2_done", {31'd0, done}, 32'd1);
        check("pop2_data", {24'd0, pop_data}, 32'h11);
        check("pop2_sp", {24'd0, sp}, 32'hFF);
        check("pop2_empty", {31'd0, empty}, 32'd1);

        cyc(1'b1, 1'b1, 8'h33);
        check("both_err", {31'd0, stack_err}, 32'd1);
        check("both_sp", {24'd0, sp}, 32'hFF);
        cyc(1'b0, 1'b0, 8'h00);
        check("both_err_clr", {31'd0, stack_err}, 32'd0);

        do_reset();
        cyc(1'b0, 1'b1, 8'h00);
        check("uf_re", {31'd0, mem_re}, {31'd0, !GUARD});
        cyc(1'b0, 1'b0, 8'h00);
        check("uf_done", {31'd0, done}, {31'd0, !GUARD});
        check("uf_err", {31'd0, stack_err}, {31'd0, GUARD});
        check("uf_sp", {24'd0, sp}, GUARD ? 32'hFF : 32'h00);

        do_reset();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 1'b0, i[7:0]);
            cyc(1'b0, 1'b0, 8'h00);
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_sp", {24'd0, sp}, 32'hFF);
        check("fill_ram", {24'd0, ram[8'hFF]}, 32'h00);
        cyc(1'b1, 1'b0, 8'hC3);
        check("of_we", {31'd0, mem_we}, {31'd0, !GUARD});
        cyc(1'b0, 1'b0, 8'h00);
        check("of_err", {31'd0, stack_err}, {31'd0, GUARD});
        check("of_ram", {24'd0, ram[8'hFF]}, GUARD ? 32'h00 : 32'hC3);
        check("of_full", {31'd0, full}, 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        check("of_err_hold", {31'd0, stack_err}, {31'd0, GUARD});

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      cyc(1'b1, 1'b0, 8'($urandom));
            else if (r < 85) cyc(1'b0, 1'b1, 8'($urandom));
            else if (r < 90) cyc(1'b1, 1'b1, 8'($urandom));
            else             cyc(1'b0, 1'b0, 8'($urandom));
        end

        do_reset();
        old_byte = ram[8'hFF];
        cyc(1'b1, 1'b0, ~old_byte);
        check("mid_we_before", {31'd0, mem_we}, 32'd1);
        push = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_we", {31'd0, mem_we}, 32'd0);
        check("mid_sp", {24'd0, sp}, 32'hFF);
        check("mid_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_done_err", {30'd0, done, stack_err}, 32'd0);
        @(posedge clk); #1;
        check("mid_ram", {24'd0, ram[8'hFF]}, {24'd0, old_byte});
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
